// File: rtl/debug_run_controller_pkg.sv
// Shared command codes, frame constants and FSM state encoding for the debug run controller.
package debug_run_controller_pkg;

    localparam logic [7:0] CMD_STEP     = 8'h01;
    localparam logic [7:0] CMD_RUN      = 8'h02;
    localparam logic [7:0] CMD_DUMP     = 8'h03;
    localparam logic [7:0] CMD_RESET    = 8'h04;
    localparam logic [7:0] HDR_BYTE_DEF = 8'hA5;

    typedef enum logic [5:0] {
        ST_IDLE = 6'b000001,
        ST_STEP = 6'b000010,
        ST_RUN  = 6'b000100,
        ST_SNAP = 6'b001000,
        ST_SEND = 6'b010000,
        ST_FIN  = 6'b100000
    } state_e;

    function automatic logic state_is_busy(input state_e s);
        return !((s == ST_IDLE) || (s == ST_FIN));
    endfunction

endpackage

// File: rtl/debug_run_controller_if.sv
// Bundles the UART command/TX FIFO side and the datapath control/probe side of the controller.
interface debug_run_controller_if #(
    parameter int DUMP_BYTES = 172
);
    logic                    rx_rdy;
    logic [7:0]              rx_bus;
    logic                    halt_in;
    logic [DUMP_BYTES*8-1:0] dp_bus;
    logic                    tx_full;
    logic                    dp_clk_en;
    logic                    dp_reset;
    logic                    tx_write;
    logic [7:0]              tx_bus;
    logic                    busy;
    logic                    halted;

    modport master (
        input  rx_rdy, rx_bus, halt_in, dp_bus, tx_full,
        output dp_clk_en, dp_reset, tx_write, tx_bus, busy, halted
    );

    modport slave (
        output rx_rdy, rx_bus, halt_in, dp_bus, tx_full,
        input  dp_clk_en, dp_reset, tx_write, tx_bus, busy, halted
    );
endinterface

// File: rtl/debug_run_controller_serializer.sv
// Streams header, snapshot bytes (LSB byte first) and an XOR checksum to the TX FIFO, one byte per free cycle.
module debug_frame_serializer
    import debug_run_controller_pkg::*;
#(
    parameter int         DUMP_BYTES = 172,
    parameter logic [7:0] HDR_BYTE   = HDR_BYTE_DEF
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    i_start,
    input  logic [DUMP_BYTES*8-1:0] i_snapshot,
    input  logic                    i_tx_full,
    output logic                    o_done,
    output logic                    o_tx_write,
    output logic [7:0]              o_tx_bus
);
    localparam int CNT_W = $clog2(DUMP_BYTES + 2);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DUMP_BYTES + 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic                    r_active;
    logic [CNT_W-1:0]        r_cnt;
    logic [7:0]              r_csum;
    logic                    r_tx_write;
    logic [7:0]              r_tx_bus;
    logic                    r_done;
    logic [CNT_W-1:0]        w_idx;
    logic [DUMP_BYTES*8-1:0] w_shift;
    logic [7:0]              w_data;
    logic [7:0]              w_byte;

    // Select the byte for the current counter position: header, data byte, or checksum.
    always_comb begin
        w_idx   = r_cnt - CNT_ONE;
        w_shift = i_snapshot >> {w_idx, 3'b000};
        w_data  = w_shift[7:0];
        w_byte  = w_data;
        if (r_cnt == {CNT_W{1'b0}}) begin
            w_byte = HDR_BYTE;
        end else if (r_cnt == CNT_LAST) begin
            w_byte = r_csum;
        end else begin
            w_byte = w_data;
        end
    end

    // Counter, checksum and registered write strobe; the strobe follows the tx_full seen last cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_active   <= 1'b0;
            r_cnt      <= {CNT_W{1'b0}};
            r_csum     <= 8'h00;
            r_tx_write <= 1'b0;
            r_tx_bus   <= 8'h00;
            r_done     <= 1'b0;
        end else begin
            r_tx_write <= 1'b0;
            r_done     <= 1'b0;
            if (i_start) begin
                r_active <= 1'b1;
                r_cnt    <= {CNT_W{1'b0}};
                r_csum   <= 8'h00;
            end else if (r_active && !i_tx_full) begin
                r_tx_write <= 1'b1;
                r_tx_bus   <= w_byte;
                if ((r_cnt != {CNT_W{1'b0}}) && (r_cnt != CNT_LAST)) begin
                    r_csum <= r_csum ^ w_data;
                end
                if (r_cnt == CNT_LAST) begin
                    r_active <= 1'b0;
                    r_done   <= 1'b1;
                end else begin
                    r_cnt <= r_cnt + CNT_ONE;
                end
            end
        end
    end

    assign o_done     = r_done;
    assign o_tx_write = r_tx_write;
    assign o_tx_bus   = r_tx_bus;

endmodule

// File: rtl/debug_run_controller.sv
// Command FSM for the debug link: gates the datapath clock enable, snapshots the probe bus and frames it out.
module debug_run_controller
    import debug_run_controller_pkg::*;
#(
    parameter int         DUMP_BYTES = 172,
    parameter logic [7:0] HDR_BYTE   = HDR_BYTE_DEF
) (
    input  logic                   clk,
    input  logic                   reset,
    debug_run_controller_if.master bus
);
    state_e                  r_state;
    state_e                  w_next;
    logic                    r_dp_reset;
    logic                    r_halted;
    logic [DUMP_BYTES*8-1:0] r_snapshot;
    logic                    w_clk_en;
    logic                    w_start;
    logic                    w_rst_req;
    logic                    w_done;

    // Next-state decode; command bytes are only honoured in IDLE and FIN.
    always_comb begin
        w_next    = r_state;
        w_clk_en  = 1'b0;
        w_start   = 1'b0;
        w_rst_req = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.rx_rdy) begin
                    case (bus.rx_bus)
                        CMD_STEP:  w_next    = ST_STEP;
                        CMD_RUN:   w_next    = ST_RUN;
                        CMD_DUMP:  w_next    = ST_SNAP;
                        CMD_RESET: w_rst_req = 1'b1;
                        default:   w_next    = ST_IDLE;
                    endcase
                end else begin
                    w_next = ST_IDLE;
                end
            end
            ST_STEP: begin
                w_clk_en = 1'b1;
                w_next   = ST_SNAP;
            end
            ST_RUN: begin
                if (bus.halt_in) begin
                    w_next = ST_SNAP;
                end else begin
                    w_clk_en = 1'b1;
                end
            end
            ST_SNAP: begin
                w_start = 1'b1;
                w_next  = ST_SEND;
            end
            ST_SEND: begin
                if (w_done) begin
                    w_next = r_halted ? ST_FIN : ST_IDLE;
                end else begin
                    w_next = ST_SEND;
                end
            end
            ST_FIN: begin
                if (bus.rx_rdy) begin
                    case (bus.rx_bus)
                        CMD_RESET: begin
                            w_rst_req = 1'b1;
                            w_next    = ST_IDLE;
                        end
                        CMD_DUMP: w_next = ST_SNAP;
                        default:  w_next = ST_FIN;
                    endcase
                end else begin
                    w_next = ST_FIN;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // State, datapath reset pulse, sticky halted flag and probe snapshot.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_dp_reset <= 1'b0;
            r_halted   <= 1'b0;
            r_snapshot <= '0;
        end else begin
            r_state    <= w_next;
            r_dp_reset <= w_rst_req;
            if (w_rst_req) begin
                r_halted <= 1'b0;
            end else if (r_state == ST_SNAP) begin
                r_halted <= r_halted | bus.halt_in;
            end
            if (r_state == ST_SNAP) begin
                r_snapshot <= bus.dp_bus;
            end
        end
    end

    debug_frame_serializer #(
        .DUMP_BYTES (DUMP_BYTES),
        .HDR_BYTE   (HDR_BYTE)
    ) u_ser (
        .clk        (clk),
        .reset      (reset),
        .i_start    (w_start),
        .i_snapshot (r_snapshot),
        .i_tx_full  (bus.tx_full),
        .o_done     (w_done),
        .o_tx_write (bus.tx_write),
        .o_tx_bus   (bus.tx_bus)
    );

    // The RUN enable is combinational on halt_in so the halting cycle itself is never clocked.
    assign bus.dp_clk_en = w_clk_en;
    assign bus.dp_reset  = r_dp_reset;
    assign bus.busy      = state_is_busy(r_state);
    assign bus.halted    = r_halted;

endmodule

// File: tb/tb_debug_run_controller.sv
// Directed, table-driven bench for debug_run_controller with a 4-byte probe bus.
module tb_debug_run_controller;
    localparam int DB = 4;

    typedef struct {
        logic [7:0]  cmd;
        logic [31:0] dp;
        int          halt_after;
        int          exp_en;
        logic        exp_halted;
    } vec_t;

    logic clk;
    logic reset;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    int   en_cnt   = 0;
    int   rst_cnt  = 0;
    int   err_overlap = 0;
    int   err_full    = 0;
    int   err_idle_wr = 0;
    logic prev_full = 1'b0;
    logic [7:0] tx_q[$];
    int         wc_q[$];
    vec_t       vecs[6];

    debug_run_controller_if #(.DUMP_BYTES(DB)) bus ();

    debug_run_controller #(.DUMP_BYTES(DB)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (bus.tx_write) begin
            tx_q.push_back(bus.tx_bus);
            wc_q.push_back(cyc);
        end
        if (bus.dp_clk_en) en_cnt <= en_cnt + 1;
        if (bus.dp_reset) rst_cnt <= rst_cnt + 1;
        if (bus.dp_clk_en && bus.dp_reset) err_overlap <= err_overlap + 1;
        if (bus.tx_write && prev_full) err_full <= err_full + 1;
        if (bus.tx_write && !bus.busy) err_idle_wr <= err_idle_wr + 1;
        prev_full <= bus.tx_full;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic issue_cmd(input logic [7:0] b);
        @(negedge clk);
        bus.rx_rdy = 1'b1;
        bus.rx_bus = b;
        @(negedge clk);
        bus.rx_rdy = 1'b0;
        bus.rx_bus = 8'h00;
    endtask

    task automatic wait_writes(input int target);
        int k;
        for (k = 0; k < 300 && tx_q.size() < target; k++) @(negedge clk);
        chk("write_timeout", 64'(tx_q.size() < target), 64'd0);
    endtask

    task automatic wait_frame(input int base);
        int k;
        for (k = 0; k < 300 && !(tx_q.size() >= base + 6 && !bus.busy); k++) @(negedge clk);
        chk("frame_timeout", 64'(k >= 300), 64'd0);
    endtask

    task automatic check_frame(input string name, input logic [31:0] dp, input int base, input int span);
        logic [7:0] e;
        logic [7:0] x;
        x = 8'h00;
        chk({name, "_len"}, 64'(tx_q.size() - base), 64'd6);
        if (tx_q.size() - base == 6) begin
            for (int i = 0; i < 6; i++) begin
                if (i == 0) e = 8'hA5;
                else if (i == 5) e = x;
                else begin
                    e = dp[8*(i-1) +: 8];
                    x = x ^ e;
                end
                chk($sformatf("%s_byte%0d", name, i), 64'(tx_q[base+i]), 64'(e));
            end
            chk({name, "_span"}, 64'(wc_q[base+5] - wc_q[base]), 64'(span));
        end
    endtask

    initial begin
        int base;
        int en0;
        int r0;

        vecs[0] = '{8'h01, 32'h44332211, -1,  1, 1'b0};
        vecs[1] = '{8'h03, 32'hDEADBEEF, -1,  0, 1'b0};
        vecs[2] = '{8'h01, 32'h00000000, -1,  1, 1'b0};
        vecs[3] = '{8'h02, 32'h80FF017E, 10, 10, 1'b1};
        vecs[4] = '{8'h02, 32'h12345678,  0,  0, 1'b1};
        vecs[5] = '{8'h01, 32'hFFFFFFFF, -1,  1, 1'b0};

        reset = 1'b1;
        bus.rx_rdy = 1'b0;
        bus.rx_bus = 8'h00;
        bus.halt_in = 1'b0;
        bus.dp_bus = '0;
        bus.tx_full = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_dp_clk_en", 64'(bus.dp_clk_en), 64'd0);
        chk("rst_dp_reset",  64'(bus.dp_reset),  64'd0);
        chk("rst_tx_write",  64'(bus.tx_write),  64'd0);
        chk("rst_tx_bus",    64'(bus.tx_bus),    64'd0);
        chk("rst_busy",      64'(bus.busy),      64'd0);
        chk("rst_halted",    64'(bus.halted),    64'd0);
        reset = 1'b0;
        @(negedge clk);

        for (int v = 0; v < 6; v++) begin
            bus.dp_bus = vecs[v].dp;
            base = tx_q.size();
            en0 = en_cnt;
            issue_cmd(vecs[v].cmd);
            if (vecs[v].halt_after >= 0) begin
                repeat (vecs[v].halt_after) @(negedge clk);
                bus.halt_in = 1'b1;
            end
            wait_frame(base);
            check_frame($sformatf("v%0d", v), vecs[v].dp, base, 5);
            chk($sformatf("v%0d_en", v), 64'(en_cnt - en0), 64'(vecs[v].exp_en));
            chk($sformatf("v%0d_halted", v), 64'(bus.halted), 64'(vecs[v].exp_halted));
            chk($sformatf("v%0d_busy", v), 64'(bus.busy), 64'd0);
            bus.halt_in = 1'b0;
            if (vecs[v].exp_halted) begin
                base = tx_q.size();
                en0 = en_cnt;
                issue_cmd(8'h01);
                repeat (5) @(negedge clk);
                chk($sformatf("v%0d_fin_step_en", v), 64'(en_cnt - en0), 64'd0);
                chk($sformatf("v%0d_fin_step_wr", v), 64'(tx_q.size() - base), 64'd0);
                chk($sformatf("v%0d_fin_halted", v), 64'(bus.halted), 64'd1);
                r0 = rst_cnt;
                issue_cmd(8'h04);
                repeat (2) @(negedge clk);
                chk($sformatf("v%0d_dp_reset", v), 64'(rst_cnt - r0), 64'd1);
                chk($sformatf("v%0d_clr_halted", v), 64'(bus.halted), 64'd0);
                chk($sformatf("v%0d_idle_busy", v), 64'(bus.busy), 64'd0);
            end
        end

        // Backpressure: full for four cycles after the first write is seen.
        bus.dp_bus = 32'h44332211;
        base = tx_q.size();
        issue_cmd(8'h01);
        wait_writes(base + 1);
        bus.tx_full = 1'b1;
        repeat (4) @(negedge clk);
        bus.tx_full = 1'b0;
        wait_frame(base);
        check_frame("bp", 32'h44332211, base, 9);

        // Async reset mid-frame after three bytes.
        bus.dp_bus = 32'hA1B2C3D4;
        base = tx_q.size();
        issue_cmd(8'h01);
        wait_writes(base + 3);
        reset = 1'b1;
        #1;
        chk("mid_rst_tx_write", 64'(bus.tx_write), 64'd0);
        chk("mid_rst_clk_en",   64'(bus.dp_clk_en), 64'd0);
        chk("mid_rst_tx_bus",   64'(bus.tx_bus), 64'd0);
        chk("mid_rst_busy",     64'(bus.busy), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (8) @(negedge clk);
        chk("mid_rst_no_more", 64'(tx_q.size() - base), 64'd3);
        bus.dp_bus = 32'h0F1E2D3C;
        base = tx_q.size();
        issue_cmd(8'h01);
        wait_frame(base);
        check_frame("after_rst", 32'h0F1E2D3C, base, 5);

        // Unknown command in IDLE, STEP command during SEND.
        base = tx_q.size();
        en0 = en_cnt;
        issue_cmd(8'h7F);
        repeat (5) @(negedge clk);
        chk("ign7f_en",   64'(en_cnt - en0), 64'd0);
        chk("ign7f_wr",   64'(tx_q.size() - base), 64'd0);
        chk("ign7f_busy", 64'(bus.busy), 64'd0);
        bus.dp_bus = 32'h55AA6699;
        issue_cmd(8'h01);
        wait_writes(base + 1);
        issue_cmd(8'h01);
        wait_frame(base);
        check_frame("ign_send", 32'h55AA6699, base, 5);
        chk("ign_send_en", 64'(en_cnt - en0), 64'd1);

        // Re-dump from FIN returns to FIN.
        bus.dp_bus = 32'h01020304;
        base = tx_q.size();
        bus.halt_in = 1'b1;
        issue_cmd(8'h02);
        wait_frame(base);
        bus.halt_in = 1'b0;
        bus.dp_bus = 32'hCAFE0001;
        base = tx_q.size();
        issue_cmd(8'h03);
        wait_frame(base);
        check_frame("redump", 32'hCAFE0001, base, 5);
        chk("redump_halted", 64'(bus.halted), 64'd1);
        issue_cmd(8'h04);
        repeat (2) @(negedge clk);
        chk("redump_clr", 64'(bus.halted), 64'd0);

        chk("inv_en_rst_overlap", 64'(err_overlap), 64'd0);
        chk("inv_write_after_full", 64'(err_full), 64'd0);
        chk("inv_write_outside_send", 64'(err_idle_wr), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
